// File: rtl/isp_ccm_v2.sv
// isp_ccm_v2: 3x3 signed fixed-point colour correction, 4-cycle latency, frame-aligned config swap.
// Optional per-frame clipped-pixel counter on clip_cnt, enabled by defining ISP_CCM_CLIP_CNT_EN.
module isp_ccm_v2_lane #(
  parameter int BITS      = 8,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 10
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [2:0][BITS:0]     pix_s1,
  input  logic [2:0][COEF_W-1:0] coef_s1,
  input  logic [BITS-1:0]        byp_pix_s1,
  input  logic                   byp_s3,
  output logic [BITS-1:0]        pix_s4,
  output logic                   clip_s4
);
  localparam int PW = BITS + 1 + COEF_W;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [SW-1:0] PMAX = (SW'(1) <<< BITS) - SW'(1);

  function automatic logic [PW-1:0] smul(input logic [BITS:0] p, input logic [COEF_W-1:0] c);
    logic signed [PW-1:0] a, b;
    a = PW'($signed(p));
    b = PW'($signed(c));
    return a * b;
  endfunction

  logic [2:0][PW-1:0]    prod_d, prod_q;
  logic signed [SW-1:0]  sum_w, shr_d, shr_q;
  logic [BITS-1:0]       byp_pix_s2_d, byp_pix_s2_q, byp_pix_s3_d, byp_pix_s3_q;
  logic [BITS-1:0]       pix_s4_d, pix_s4_q;
  logic                  clip_s4_d, clip_s4_q;

  always_comb begin
    for (int j = 0; j < 3; j++) prod_d[j] = smul(pix_s1[j], coef_s1[j]);
    byp_pix_s2_d = byp_pix_s1;
    byp_pix_s3_d = byp_pix_s2_q;
    // sum + half LSB then floor shift gives round-half-up
    sum_w = SW'($signed(prod_q[0])) + SW'($signed(prod_q[1])) + SW'($signed(prod_q[2])) + RND;
    shr_d = sum_w >>> COEF_FRAC;
    pix_s4_d  = shr_q[BITS-1:0];
    clip_s4_d = 1'b0;
    if (byp_s3) begin
      pix_s4_d = byp_pix_s3_q;
    end else if (shr_q < 0) begin
      pix_s4_d  = '0;
      clip_s4_d = 1'b1;
    end else if (shr_q > PMAX) begin
      pix_s4_d  = '1;
      clip_s4_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      prod_q       <= '0;
      shr_q        <= '0;
      byp_pix_s2_q <= '0;
      byp_pix_s3_q <= '0;
      pix_s4_q     <= '0;
      clip_s4_q    <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      shr_q        <= shr_d;
      byp_pix_s2_q <= byp_pix_s2_d;
      byp_pix_s3_q <= byp_pix_s3_d;
      pix_s4_q     <= pix_s4_d;
      clip_s4_q    <= clip_s4_d;
    end
  end

  assign pix_s4  = pix_s4_q;
  assign clip_s4 = clip_s4_q;
endmodule

module isp_ccm_v2 #(
  parameter int BITS      = 8,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 10,
  parameter int CNT_W     = 24
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [9*COEF_W-1:0]   cfg_coef,
  input  logic                  cfg_bypass,
  input  logic                  cfg_commit,
  output logic                  cfg_pending,
  output logic                  cfg_applied,
  input  logic                  in_href,
  input  logic                  in_vsync,
  input  logic [BITS-1:0]       in_r,
  input  logic [BITS-1:0]       in_g,
  input  logic [BITS-1:0]       in_b,
  output logic                  out_href,
  output logic                  out_vsync,
  output logic [BITS-1:0]       out_r,
  output logic [BITS-1:0]       out_g,
  output logic [BITS-1:0]       out_b,
  output logic [CNT_W-1:0]      clip_cnt
);
  localparam int STAGES = 4;
  localparam logic [COEF_W-1:0]   ONE   = COEF_W'(1) << COEF_FRAC;
  localparam logic [COEF_W-1:0]   ZRO   = '0;
  localparam logic [9*COEF_W-1:0] IDENT = {ONE, {3{ZRO}}, ONE, {3{ZRO}}, ONE};

  logic [8:0][COEF_W-1:0] shd_coef_d, shd_coef_q, act_coef_d, act_coef_q, coef_s1_d, coef_s1_q;
  logic                   shd_byp_d, shd_byp_q, act_byp_d, act_byp_q;
  logic                   pend_d, pend_q, appl_d, appl_q, vs_d, vs_q, fs;
  logic [STAGES:1]        vld_pipe_d, vld_pipe_q, vs_pipe_d, vs_pipe_q;
  logic [2:0][BITS:0]     pix_s1_d, pix_s1_q;
  logic                   byp_s1_d, byp_s1_q, byp_s2_d, byp_s2_q, byp_s3_d, byp_s3_q;
  logic [2:0][BITS-1:0]   lane_pix;
  logic [2:0]             lane_clip;

  assign fs = in_vsync & ~vs_q;

  // A commit landing on the frame-start cycle bypasses the shadow and goes live directly.
  always_comb begin
    shd_coef_d = shd_coef_q;
    shd_byp_d  = shd_byp_q;
    act_coef_d = act_coef_q;
    act_byp_d  = act_byp_q;
    pend_d     = pend_q;
    appl_d     = 1'b0;
    if (cfg_commit) begin
      shd_coef_d = cfg_coef;
      shd_byp_d  = cfg_bypass;
    end
    if (cfg_commit && fs) begin
      act_coef_d = cfg_coef;
      act_byp_d  = cfg_bypass;
      pend_d     = 1'b0;
      appl_d     = 1'b1;
    end else if (cfg_commit) begin
      pend_d = 1'b1;
    end else if (fs && pend_q) begin
      act_coef_d = shd_coef_q;
      act_byp_d  = shd_byp_q;
      pend_d     = 1'b0;
      appl_d     = 1'b1;
    end
  end

  // S1 latches the next-active matrix so the fs-cycle pixel already sees the new one.
  always_comb begin
    vs_d       = in_vsync;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_href};
    vs_pipe_d  = {vs_pipe_q[STAGES-1:1], in_vsync};
    pix_s1_d   = {{1'b0, in_b}, {1'b0, in_g}, {1'b0, in_r}};
    coef_s1_d  = act_coef_d;
    byp_s1_d   = act_byp_d;
    byp_s2_d   = byp_s1_q;
    byp_s3_d   = byp_s2_q;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      shd_coef_q <= IDENT;
      shd_byp_q  <= 1'b0;
      act_coef_q <= IDENT;
      act_byp_q  <= 1'b0;
      pend_q     <= 1'b0;
      appl_q     <= 1'b0;
      vs_q       <= 1'b0;
      vld_pipe_q <= '0;
      vs_pipe_q  <= '0;
      pix_s1_q   <= '0;
      coef_s1_q  <= '0;
      byp_s1_q   <= 1'b0;
      byp_s2_q   <= 1'b0;
      byp_s3_q   <= 1'b0;
    end else begin
      shd_coef_q <= shd_coef_d;
      shd_byp_q  <= shd_byp_d;
      act_coef_q <= act_coef_d;
      act_byp_q  <= act_byp_d;
      pend_q     <= pend_d;
      appl_q     <= appl_d;
      vs_q       <= vs_d;
      vld_pipe_q <= vld_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      pix_s1_q   <= pix_s1_d;
      coef_s1_q  <= coef_s1_d;
      byp_s1_q   <= byp_s1_d;
      byp_s2_q   <= byp_s2_d;
      byp_s3_q   <= byp_s3_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    isp_ccm_v2_lane #(.BITS(BITS), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_lane (
      .pclk       (pclk),
      .rst        (rst),
      .pix_s1     (pix_s1_q),
      .coef_s1    (coef_s1_q[3*i +: 3]),
      .byp_pix_s1 (pix_s1_q[i][BITS-1:0]),
      .byp_s3     (byp_s3_q),
      .pix_s4     (lane_pix[i]),
      .clip_s4    (lane_clip[i])
    );
  end

  assign cfg_pending = pend_q;
  assign cfg_applied = appl_q;
  assign out_href    = vld_pipe_q[STAGES];
  assign out_vsync   = vs_pipe_q[STAGES];
  assign out_r       = out_href ? lane_pix[0] : '0;
  assign out_g       = out_href ? lane_pix[1] : '0;
  assign out_b       = out_href ? lane_pix[2] : '0;

`ifdef ISP_CCM_CLIP_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q, clip_cnt_d, clip_cnt_q;
  logic             ovs_d, ovs_q, hit, ovs_rise;

  // A clipped pixel coinciding with the out_vsync rise belongs to the new frame.
  always_comb begin
    hit        = out_href & (|lane_clip);
    ovs_rise   = out_vsync & ~ovs_q;
    ovs_d      = out_vsync;
    cnt_d      = cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (ovs_rise) begin
      clip_cnt_d = cnt_q;
      cnt_d      = CNT_W'(hit);
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      clip_cnt_q <= '0;
      ovs_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clip_cnt_q <= clip_cnt_d;
      ovs_q      <= ovs_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = |lane_clip;
  assign clip_cnt    = '0;
`endif
endmodule

// File: tb/tb_isp_ccm_v2.sv
// Bench for isp_ccm_v2: directed test-plan cases plus randomized frames against a queue-based model.
module tb_isp_ccm_v2;
  localparam int BITS = 8, COEF_W = 16, COEF_FRAC = 10, CNT_W = 24;

  logic                pclk = 1'b0;
  logic                rst  = 1'b1;
  logic [9*COEF_W-1:0] cfg_coef = '0;
  logic                cfg_bypass = 1'b0, cfg_commit = 1'b0;
  logic                cfg_pending, cfg_applied;
  logic                in_href = 1'b0, in_vsync = 1'b0;
  logic [BITS-1:0]     in_r = '0, in_g = '0, in_b = '0;
  logic                out_href, out_vsync;
  logic [BITS-1:0]     out_r, out_g, out_b;
  logic [CNT_W-1:0]    clip_cnt;

  isp_ccm_v2 #(.BITS(BITS), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .CNT_W(CNT_W)) dut (
    .pclk(pclk), .rst(rst), .cfg_coef(cfg_coef), .cfg_bypass(cfg_bypass), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .cfg_applied(cfg_applied), .in_href(in_href), .in_vsync(in_vsync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_href(out_href), .out_vsync(out_vsync),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .clip_cnt(clip_cnt)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {bit h; bit v; bit clp; int r; int g; int b;} px_t;
  px_t hist[$];
  int  act[9], shd[9], cf[9];
  bit  act_byp, shd_byp, pend, appl, pvs, m_ovs;
  int  m_cnt, m_clip_cnt;

  function automatic void model_reset();
    px_t z;
    z = '{default: 0};
    hist.delete();
    repeat (4) hist.push_back(z);
    for (int k = 0; k < 9; k++) act[k] = (k % 4 == 0) ? (1 << COEF_FRAC) : 0;
    shd = act;
    act_byp = 0; shd_byp = 0; pend = 0; appl = 0; pvs = 0; m_ovs = 0;
    m_cnt = 0; m_clip_cnt = 0;
  endfunction

  // Real-valued matrix product, rounded half up, then clamped to the pixel range by the caller.
  function automatic longint mac(input int i);
    longint s;
    s = longint'(act[3*i]) * longint'(in_r) + longint'(act[3*i+1]) * longint'(in_g)
      + longint'(act[3*i+2]) * longint'(in_b);
    return (s + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
  endfunction

  function automatic int clamp(input longint v);
    return (v < 0) ? 0 : (v > 255) ? 255 : int'(v);
  endfunction

  function automatic void load_cfg(input bit byp);
    for (int k = 0; k < 9; k++) cfg_coef[k*COEF_W +: COEF_W] = COEF_W'(cf[k]);
    cfg_bypass = byp;
    cfg_commit = 1'b1;
  endfunction

  function automatic void cf_ident(input int d);
    for (int k = 0; k < 9; k++) cf[k] = (k % 4 == 0) ? d : 0;
  endfunction

  task automatic tick();
    px_t p, o, e;
    bit fs, rise, hit;
    int c[9];
    longint v[3];
    @(posedge pclk);
    for (int k = 0; k < 9; k++) c[k] = int'($signed(cfg_coef[k*COEF_W +: COEF_W]));
    fs = in_vsync && !pvs;
    pvs = in_vsync;
    appl = 0;
    if (cfg_commit) begin shd = c; shd_byp = cfg_bypass; end
    if (cfg_commit && fs) begin act = c; act_byp = cfg_bypass; pend = 0; appl = 1; end
    else if (cfg_commit) pend = 1;
    else if (fs && pend) begin act = shd; act_byp = shd_byp; pend = 0; appl = 1; end
    p.h = in_href; p.v = in_vsync;
    if (act_byp) begin
      p.r = in_r; p.g = in_g; p.b = in_b; p.clp = 0;
    end else begin
      for (int i = 0; i < 3; i++) v[i] = mac(i);
      p.r = clamp(v[0]); p.g = clamp(v[1]); p.b = clamp(v[2]);
      p.clp = (p.r != v[0]) || (p.g != v[1]) || (p.b != v[2]);
    end
    hist.push_front(p);
    o = hist.pop_back();
    rise = o.v && !m_ovs;
    m_ovs = o.v;
    hit = o.h && o.clp;
    if (rise) begin m_clip_cnt = m_cnt; m_cnt = hit; end
    else if (hit) m_cnt++;
    #1;
    e = hist[3];
    chk("href", out_href, e.h);
    chk("vsync", out_vsync, e.v);
    chk("r", out_r, e.h ? e.r : 0);
    chk("g", out_g, e.h ? e.g : 0);
    chk("b", out_b, e.h ? e.b : 0);
    chk("pending", cfg_pending, pend);
    chk("applied", cfg_applied, appl);
`ifdef ISP_CCM_CLIP_CNT_EN
    chk("clip_cnt", clip_cnt, m_clip_cnt);
`else
    chk("clip_cnt", clip_cnt, 0);
`endif
    cfg_commit = 1'b0;
  endtask

  task automatic px(input int r, g, b, input int er, eg, eb, input string tag);
    in_href = 1; in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    tick();
    in_href = 0;
    repeat (3) tick();
    chk({tag, "_r"}, out_r, er);
    chk({tag, "_g"}, out_g, eg);
    chk({tag, "_b"}, out_b, eb);
  endtask

  initial begin
    model_reset();
    in_href = 1; in_r = 8'd100;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_href", out_href, 0);
    chk("rst_r", out_r, 0);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_appl", cfg_applied, 0);
    in_href = 0; in_r = 0;
    rst = 0;

    px(100, 50, 200, 100, 50, 200, "ident");
    tick();
    chk("gate_r", out_r, 0);

    // Mid-frame commit stays pending; the fs pixel takes the new matrix.
    cf_ident(1024); cf[0] = 512; cf[1] = -1024;
    load_cfg(0); tick();
    chk("pend_set", cfg_pending, 1);
    px(3, 0, 0, 3, 0, 0, "old_mtx");
    in_vsync = 1; in_href = 1; in_r = 3; in_g = 0; in_b = 0;
    tick();
    chk("appl_pulse", cfg_applied, 1);
    chk("pend_clr", cfg_pending, 0);
    in_href = 0;
    repeat (3) tick();
    chk("round_r", out_r, 2);
    chk("appl_once", cfg_applied, 0);
    px(10, 20, 0, 0, 20, 0, "clip_lo");

    // Commit colliding with fs: live immediately, 10 overflowing pixels in this frame.
    in_vsync = 0; repeat (2) tick();
    cf_ident(1024); cf[0] = 2048;
    load_cfg(0); in_vsync = 1; tick();
    chk("coll_pend", cfg_pending, 0);
    chk("coll_appl", cfg_applied, 1);
    for (int n = 0; n < 10; n++) begin
      in_href = 1; in_r = 200; in_g = 10; in_b = 10; tick();
    end
    in_href = 0;
    repeat (3) tick();
    chk("ovf_r", out_r, 255);
    chk("ovf_g", out_g, 10);
    in_vsync = 0; repeat (2) tick();
    in_vsync = 1; repeat (6) tick();
`ifdef ISP_CCM_CLIP_CNT_EN
    chk("clip_cnt10", clip_cnt, 10);
`endif

    // Two commits before fs: the later one wins.
    in_vsync = 0; tick();
    cf_ident(1024); cf[0] = 2048; load_cfg(0); tick();
    cf_ident(1024); cf[0] = 512;  load_cfg(0); tick();
    chk("dbl_pend", cfg_pending, 1);
    in_vsync = 1; in_href = 1; in_r = 101; in_g = 0; in_b = 0;
    tick();
    in_href = 0;
    repeat (3) tick();
    chk("dbl_r", out_r, 51);

    // Bypass with a matrix that would otherwise double every channel.
    in_vsync = 0; tick();
    cf_ident(2048); load_cfg(1); in_vsync = 1;
    px(7, 8, 9, 7, 8, 9, "bypass");

    // Async reset mid-line.
    in_vsync = 0;
    for (int n = 0; n < 3; n++) begin
      in_href = 1; in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom); tick();
    end
    rst = 1;
    #1;
    chk("mrst_href", out_href, 0);
    chk("mrst_r", out_r, 0);
    chk("mrst_g", out_g, 0);
    model_reset();
    @(posedge pclk);
    #1;
    rst = 0; in_href = 0;
    px(100, 50, 200, 100, 50, 200, "post_rst");

    // Randomized frames with random matrices, bypass and commits.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_vsync = (cyc % 64) < 3;
      in_href  = ((cyc % 64) >= 6) && ($urandom_range(0, 3) != 0);
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < 9; k++) cf[k] = int'($urandom_range(0, 5119)) - 2048;
        load_cfg($urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/isp_ccm_v2.md
Name: isp_ccm_v2

Overview:
Parametrised second-generation color correction matrix for the RGB pipeline. It applies a 3x3 signed fixed-point matrix to each pixel, with configurable pixel width, coefficient width and fraction bits, and rounds to nearest. Coefficients and bypass are double-buffered and take effect only at a frame boundary, so a frame never mixes two matrices. The block drops in where the first-generation CCM sat: after demosaic/white balance, before gamma.

Parameters:
BITS, 8, pixel width per channel
COEF_W, 16, signed coefficient width (two's complement)
COEF_FRAC, 10, fraction bits of each coefficient; the product sum is shifted right by this amount; must be >= 1 and < COEF_W
CNT_W, 24, clip-counter width; used only when ISP_CCM_CLIP_CNT_EN is defined

Ports:
pclk  input  1  pixel clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
cfg_coef  input  9*COEF_W  matrix, packed rr,rg,rb,gr,gg,gb,br,bg,bb with rr at LSBs
cfg_bypass  input  1  requested bypass mode
cfg_commit  input  1  1-cycle pulse; captures cfg_coef/cfg_bypass into shadow, sets pending
cfg_pending  output  1  shadow holds values not yet applied
cfg_applied  output  1  1-cycle pulse when shadow is copied to active
in_href  input  1  line valid
in_vsync  input  1  frame sync, rising edge = frame start
in_r, in_g, in_b  input  BITS each  input pixel
out_href, out_vsync  output  1 each  delayed syncs
out_r, out_g, out_b  output  BITS each  corrected pixel, forced 0 when out_href=0
clip_cnt  output  CNT_W  pixels clipped in the last completed frame (macro only)

Behaviour:
- Reset: active matrix = identity (diagonal = 1<<COEF_FRAC, off-diagonal 0); active bypass = 0; shadow = identity, bypass 0; cfg_pending=0, cfg_applied=0; all pipeline and delay registers 0; all outputs 0.
- Frame-start detect: vs_d <= in_vsync; fs = in_vsync & ~vs_d.
- Shadow/active control:
  - cfg_commit: shadow <= cfg_coef/cfg_bypass; pending <= 1.
  - fs & pending: active <= shadow; pending <= 0; cfg_applied pulses the next cycle.
  - cfg_commit and fs in the same cycle: the cfg_coef/cfg_bypass values on the ports go straight to active; pending ends 0; cfg_applied pulses.
  - cfg_commit while already pending: shadow is overwritten; pending stays 1.
  - fs without pending: no change and no pulse.
- Datapath pipeline, fixed latency 4 cycles:
  - S1: register pixels zero-extended to BITS+1 signed.
  - S2: nine signed products, each BITS+1+COEF_W bits.
  - S3: per channel, sum of three products (width +2) + (1<<(COEF_FRAC-1)), then arithmetic shift right by COEF_FRAC. This is round-half-up.
  - S4: clip. Negative -> 0; > 2^BITS-1 -> 2^BITS-1; else low BITS.
- Bypass (active): S4 outputs the S1 pixel values delayed to the same 4-cycle latency; syncs unchanged.
- Active matrix/bypass is sampled at S1. A change applied at fs affects pixels entering on or after the fs cycle.
- href/vsync pass through a 4-deep shift register. Outputs are gated by out_href.
- Async reset mid-frame clears the pipeline immediately; output resumes cleanly on the next input pixels.

Optional Feature:
ISP_CCM_CLIP_CNT_EN.
- Defined: an internal counter increments for each S4 pixel with href high where any channel clipped (low or high). The counter is not incremented in bypass, and it saturates at 2^CNT_W-1.
- On the rising edge of out_vsync, clip_cnt <= counter and the counter is cleared. If a clipped pixel lands in that same cycle, it counts toward the new frame.
- Reset value of clip_cnt and the counter is 0.
- Not defined: clip_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Identity after reset, BITS=8, FRAC=10: in R,G,B=100,50,200 with href -> out 100,50,200 exactly 4 cycles later; href=0 -> outputs 0.
- Rounding and sign: commit rr=512, rg=-1024 and fs; R=3, G=0 -> out_r=2 (1.5 rounds up). R=10, G=20 -> out_r=0, clipped low.
- Overflow: rr=2048, R=200 -> out_r=255. With the macro, a frame of 10 such pixels -> clip_cnt=10 after the next out_vsync rise.
- Frame-boundary update: commit mid-frame -> cfg_pending=1, outputs still use the old matrix; at in_vsync rise, cfg_applied pulses once and cfg_pending=0. The first pixel after fs uses the new matrix.
- Collisions: commit in the same cycle as fs -> applied immediately, pending=0. Two commits before fs -> second values applied.
- Bypass and reset: commit bypass=1 with fs; in 7,8,9 -> out 7,8,9 after 4 cycles. Assert rst mid-line -> all outputs 0 at once, active matrix returns to identity.
